// File: rtl/spi_frame_pkg.sv
// Shared types and helpers for the SPI frame master: opcodes, FSM states and frame packing.
package spi_frame_pkg;

  localparam int unsigned FRAME_W = 11;
  localparam int unsigned DATA_W  = 8;

  typedef enum logic [1:0] {
    OP_WR_ADDR = 2'b00,
    OP_WR_DATA = 2'b01,
    OP_RD_ADDR = 2'b10,
    OP_RD_DATA = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    StIdle,
    StShift,
    StWait,
    StCapt,
    StGap
  } state_e;

  // Bit 10 repeats op[1] so the slave sees the read/write direction first.
  function automatic logic [FRAME_W-1:0] build_frame(input op_e op,
                                                     input logic [DATA_W-1:0] data);
    logic [1:0] op_bits;
    op_bits = op;
    return {op_bits[1], op_bits, data};
  endfunction

endpackage

// File: rtl/spi_frame_shifter.sv
// Loadable 11-bit parallel-to-serial transmit register and 8-bit serial-to-parallel
// receive register, both MSB first.
module spi_frame_shifter
  import spi_frame_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [FRAME_W-1:0] frame,
  input  logic               shift_en,
  input  logic               capt_en,
  input  logic               miso,
  output logic               mosi,
  output logic [DATA_W-1:0]  rx_next
);

  logic [FRAME_W-1:0] tx_q;
  logic [DATA_W-1:0]  rx_q;

  // Zero fill means MOSI falls back to 0 once the whole frame has been shifted out.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_q <= '0;
      rx_q <= '0;
    end else begin
      if (load) begin
        tx_q <= frame;
      end else if (shift_en) begin
        tx_q <= {tx_q[FRAME_W-2:0], 1'b0};
      end
      if (capt_en) begin
        rx_q <= rx_next;
      end
    end
  end

  assign rx_next = {rx_q[DATA_W-2:0], miso};
  assign mosi    = tx_q[FRAME_W-1];

endmodule

// File: rtl/spi_frame_master.sv
// SPI master driving 11-bit command frames and capturing 8-bit read data.
// Optional op-sequence checking is enabled by defining SPI_FRAME_MASTER_SEQ_CHECK_EN.
module spi_frame_master
  import spi_frame_pkg::*;
#(
  parameter int unsigned GAP_CYCLES   = 2,
  parameter int unsigned MISO_LATENCY = 2,
  parameter int unsigned CNT_W        = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              busy,
  output logic              err,
  output logic              SS_n,
  output logic              MOSI,
  input  logic              MISO
);

  localparam logic [CNT_W-1:0] LastBit  = CNT_W'(FRAME_W - 1);
  localparam logic [CNT_W-1:0] WaitLast = CNT_W'(MISO_LATENCY - 2);
  localparam logic [CNT_W-1:0] CaptLast = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] GapLast  = CNT_W'(GAP_CYCLES - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  op_e               op_q;
  logic              ready_q, ready_d;
  logic              busy_q, busy_d;
  logic              ss_n_q, ss_n_d;
  logic              rsp_valid_q;
  logic [DATA_W-1:0] rsp_data_q;

  logic              accept;
  logic              load, shift_en, capt_en, rsp_fire;
  logic [DATA_W-1:0] rx_next;

  assign accept = ready_q & cmd_valid;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    load     = 1'b0;
    shift_en = 1'b0;
    capt_en  = 1'b0;
    rsp_fire = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = StShift;
          cnt_d   = '0;
          load    = 1'b1;
        end
      end
      StShift: begin
        shift_en = 1'b1;
        if (cnt_q == LastBit) begin
          cnt_d = '0;
          if (op_q == OP_RD_DATA) begin
            state_d = (MISO_LATENCY > 1) ? StWait : StCapt;
          end else begin
            state_d = StGap;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      StWait: begin
        if (cnt_q == WaitLast) begin
          state_d = StCapt;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      StCapt: begin
        capt_en = 1'b1;
        if (cnt_q == CaptLast) begin
          state_d  = StGap;
          cnt_d    = '0;
          rsp_fire = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      StGap: begin
        if (cnt_q == GapLast) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase

    // Outputs are registered from the next state so they line up with the state itself.
    ready_d = (state_d == StIdle);
    busy_d  = (state_d != StIdle);
    ss_n_d  = !(state_d inside {StShift, StWait, StCapt});
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      op_q        <= OP_WR_ADDR;
      ready_q     <= 1'b0;
      busy_q      <= 1'b0;
      ss_n_q      <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ready_q     <= ready_d;
      busy_q      <= busy_d;
      ss_n_q      <= ss_n_d;
      rsp_valid_q <= rsp_fire;
      if (load) begin
        op_q <= op_e'(cmd_op);
      end
      if (rsp_fire) begin
        rsp_data_q <= rx_next;
      end
    end
  end

  spi_frame_shifter u_shifter (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .frame    (build_frame(op_e'(cmd_op), cmd_data)),
    .shift_en (shift_en),
    .capt_en  (capt_en),
    .miso     (MISO),
    .mosi     (MOSI),
    .rx_next  (rx_next)
  );

`ifdef SPI_FRAME_MASTER_SEQ_CHECK_EN
  logic have_last_q;
  op_e  last_op_q;
  logic err_q;
  logic seq_bad;

  always_comb begin
    seq_bad = 1'b0;
    case (op_e'(cmd_op))
      OP_WR_DATA: seq_bad = !have_last_q ||
                            !(last_op_q inside {OP_WR_ADDR, OP_WR_DATA});
      OP_RD_DATA: seq_bad = !have_last_q || (last_op_q != OP_RD_ADDR);
      default:    seq_bad = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      have_last_q <= 1'b0;
      last_op_q   <= OP_WR_ADDR;
      err_q       <= 1'b0;
    end else if (accept) begin
      have_last_q <= 1'b1;
      last_op_q   <= op_e'(cmd_op);
      if (seq_bad) begin
        err_q <= 1'b1;
      end
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign cmd_ready = ready_q;
  assign busy      = busy_q;
  assign SS_n      = ss_n_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;

endmodule

// File: doc/spi_frame_master.md
Name: spi_frame_master

Overview:
- Single-clock SPI master that drives the 11-bit command frames consumed by the SPI/RAM slave wrapper (MOSI, SS_n), and captures the 8-bit read data the slave returns on MISO.
- Sits between a host-side valid/ready command port and the SPI pins.
- Serves as the active initiator in integration benches and in the SoC-side controller.

Parameters:
- GAP_CYCLES, 2, minimum cycles SS_n stays high between frames (>=1).
- MISO_LATENCY, 2, cycles from the last MOSI bit to the first MISO sample (>=1).
- CNT_W, 5, width of the internal bit/wait counter.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  host command request.
- cmd_ready  out  1  master idle and able to accept.
- cmd_op  in  2  frame opcode, placed in frame bits [9:8]: 00 wr-addr, 01 wr-data, 10 rd-addr, 11 rd-data.
- cmd_data  in  8  address or data byte, frame bits [7:0].
- rsp_valid  out  1  one-cycle pulse; rsp_data is valid.
- rsp_data  out  8  byte captured from MISO.
- busy  out  1  frame in progress (SS_n low or in gap).
- err  out  1  sticky protocol error (optional feature only; otherwise tied 0).
- SS_n  out  1  slave select, active low.
- MOSI  out  1  serial data to slave.
- MISO  in  1  serial data from slave.

Behaviour:
- Reset values:
  - SS_n=1, MOSI=0, cmd_ready=0, rsp_valid=0, rsp_data=0, busy=0, err=0.
  - State is IDLE; cmd_ready rises the cycle after rst deasserts.
- Accept: cmd_valid & cmd_ready at posedge latches the frame {cmd_op[1], cmd_op, cmd_data}. Bit 10 equals op[1]: 0 = write, 1 = read. cmd_ready drops next cycle.
- FSM states: IDLE -> SHIFT -> (WAIT -> CAPT, rd-data only) -> GAP -> IDLE.
- Cycle numbering: cycle 0 is the first cycle with SS_n=0 (the cycle after accept).
  - SHIFT: MOSI = frame bit 10 in cycle 0, down to bit 0 in cycle 10, MSB first, registered outputs.
  - For ops 00/01/10: SS_n=1 in cycle 11, then GAP.
  - WAIT (op 11): SS_n held low, MOSI=0, for MISO_LATENCY-1 cycles after cycle 10.
  - CAPT: MISO sampled on cycles 10+MISO_LATENCY through 17+MISO_LATENCY, MSB first, into the shift register. With defaults this is cycles 12..19.
  - After capture: SS_n=1 the following cycle; rsp_valid=1 and rsp_data updated in that same cycle, for exactly one cycle.
  - rsp_data holds its value until the next read completes.
- GAP: SS_n=1 for GAP_CYCLES cycles, busy=1. Then IDLE with cmd_ready=1.
- Back-to-back: the earliest next accept is the first IDLE cycle. No command queueing; cmd_valid while cmd_ready=0 is ignored and must be held by the host.
- rst mid-frame: in the same posedge, SS_n=1, MOSI=0, abort without rsp_valid, return to IDLE. A partial frame is never completed.
- No response is produced for write or rd-addr ops.
- Counters saturate: bit counter 0..10, wait and capture counters reused. CNT_W must hold max(10, MISO_LATENCY+8).

Optional Feature:
- Macro SPI_FRAME_MASTER_SEQ_CHECK_EN.
- When defined, a tracker records the last accepted op. These cases set err (sticky until rst):
  - op 01 not immediately preceded by op 00 or 01;
  - op 11 not immediately preceded by op 10.
- The offending frame is still sent unchanged.
- When undefined: err is constant 0 and no tracker logic exists.

Decomposition:
- Package spi_frame_pkg:
  - enum op_e {OP_WR_ADDR=2'b00, OP_WR_DATA=2'b01, OP_RD_ADDR=2'b10, OP_RD_DATA=2'b11};
  - FSM state enum;
  - FRAME_W=11 and DATA_W=8 constants;
  - function build_frame(op, data).
- One sub-module, spi_frame_shifter: a loadable 11-bit parallel-to-serial / 8-bit serial-to-parallel shift register with a shift/capture enable. The FSM stays in the top.

Test Plan:
- Write frame: op 00, data 8'hA5 -> SS_n low cycles 0..10, MOSI sequence 0,0,0,1,0,1,0,0,1,0,1; SS_n high at cycle 11; no rsp_valid.
- Read data: op 10 data 8'h3C, then op 11 data 8'h00, with slave model returning 8'h5A on MISO cycles 12..19 -> rsp_valid pulse at cycle 20, rsp_data=8'h5A, SS_n high at cycle 20.
- Back-to-back: cmd_valid held high for two op 01 commands -> second SS_n fall exactly 1+GAP_CYCLES cycles (3 with defaults) after the first SS_n rise.
- Reset mid-frame: rst asserted at cycle 5 of an op 11 frame -> SS_n=1 and MOSI=0 next posedge, rsp_valid never pulses, cmd_ready=1 one cycle after rst drops.
- MISO_LATENCY=4 build: op 11 -> MISO sampled cycles 14..21, rsp_valid at cycle 22.
- With SPI_FRAME_MASTER_SEQ_CHECK_EN: op 11 sent directly after reset -> err=1 and stays 1; frame still transmitted; without the macro, err stays 0.
